// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin sharing of one registered ALU with a tagged response FIFO
module alu_issue_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int RSP_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [4*NUM_REQ-1:0] req_opcode,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [3:0] alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic rsp_valid,
  output logic [ID_W-1:0] rsp_id,
  output logic [31:0] rsp_result,
  output logic rsp_illegal,
  input  logic rsp_ready
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  logic [ID_W-1:0] rr_ptr, gid, idx, tag_id;
  logic tag_ill, inflight, found, can_issue, pop, ill;
  logic [CW-1:0] count;
  logic [PW-1:0] wptr, rptr;
  logic [ID_W+32:0] mem [RSP_DEPTH];
  assign rsp_valid = count != '0;
  assign pop = rsp_valid && rsp_ready;
  // credit counts the in-flight op so a result always has a FIFO slot waiting
  assign can_issue = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop) < (CW+1)'(RSP_DEPTH);
  always_comb begin
    found = 1'b0;
    gid = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gid = idx;
      end
    end
    found = found && can_issue && !rst;
  end
  assign req_ready = found ? NUM_REQ'(1) << gid : '0;
  assign alu_opcode = found ? req_opcode[{gid, 2'b00} +: 4] : 4'hf;
  assign alu_a = found ? req_a[{gid, 5'b00000} +: 32] : '0;
  assign alu_b = found ? req_b[{gid, 5'b00000} +: 32] : '0;
  assign ill = alu_opcode inside {4'd3, 4'd5} || alu_opcode >= 4'd11;
  assign {rsp_id, rsp_illegal, rsp_result} = mem[rptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      rr_ptr <= '0;
      count <= '0;
      wptr <= '0;
      rptr <= '0;
      tag_id <= '0;
      tag_ill <= 1'b0;
    end else begin
      inflight <= found;
      if (found) begin
        tag_id <= gid;
        tag_ill <= ill;
        rr_ptr <= gid == ID_W'(NUM_REQ - 1) ? '0 : gid + 1'b1;
      end
      if (inflight) begin
        mem[wptr] <= {tag_id, tag_ill, alu_result};
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(inflight) - CW'(pop);
    end
  end
  always_ff @(posedge clk)
    if (!rst && inflight && !pop) assert (count != CW'(RSP_DEPTH));
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: directed and random checks against a transaction-level scoreboard
module tb_alu_issue_arbiter;
  localparam int N = 4, IW = 2, D = 2;
  logic clk = 1'b0;
  logic rst, rsp_valid, rsp_illegal, rsp_ready;
  logic [N-1:0] req_valid, req_ready;
  logic [4*N-1:0] req_opcode;
  logic [32*N-1:0] req_a, req_b;
  logic [3:0] alu_opcode;
  logic [31:0] alu_a, alu_b, alu_result, rsp_result;
  logic [IW-1:0] rsp_id;
  logic srst, srdy;
  logic [N-1:0] sv;
  logic [4*N-1:0] so;
  logic [32*N-1:0] sa, sb;
  int n_cmp = 0, n_bad = 0, cyc = 0, rr = 0, grants;
  typedef struct {int id; logic ill; logic [31:0] res; int avail;} rsp_t;
  rsp_t q[$];

  alu_issue_arbiter #(.NUM_REQ(N), .ID_W(IW), .RSP_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .alu_opcode(alu_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_illegal(rsp_illegal), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a * b;
      4'd4: return a & b;
      4'd6: return a | b;
      4'd7: return a ^ b;
      4'd8: return a << b[4:0];
      4'd9: return a >> b[4:0];
      4'd10: return $signed(a) >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic illeg(input logic [3:0] op);
    return op inside {4'd3, 4'd5, [4'd11:4'd15]};
  endfunction

  always_ff @(posedge clk) alu_result <= alu_ref(alu_opcode, alu_a, alu_b);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    int g;
    logic exp_v, pop;
    logic [N-1:0] exp_rdy;
    rsp_t e;
    @(posedge clk);
    cyc++;
    #1;
    rst = srst; req_valid = sv; req_opcode = so; req_a = sa; req_b = sb; rsp_ready = srdy;
    @(negedge clk);
    exp_v = !srst && q.size() > 0 && q[0].avail <= cyc;
    pop = exp_v && srdy;
    g = -1;
    if (!srst && q.size() - int'(pop) < D)
      for (int k = 0; k < N; k++)
        if (g < 0 && sv[(rr + k) % N]) g = (rr + k) % N;
    exp_rdy = g < 0 ? '0 : N'(1) << g;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (g >= 0) begin
      check("alu_opcode", 64'(alu_opcode), 64'(so[4*g +: 4]));
      check("alu_a", 64'(alu_a), 64'(sa[32*g +: 32]));
      check("alu_b", 64'(alu_b), 64'(sb[32*g +: 32]));
    end else check("alu_idle_op", 64'(alu_opcode), 64'hf);
    if (!srst) begin
      check("rsp_valid", 64'(rsp_valid), 64'(exp_v));
      if (exp_v) begin
        check("rsp_id", 64'(rsp_id), 64'(q[0].id));
        check("rsp_result", 64'(rsp_result), 64'(q[0].res));
        check("rsp_illegal", 64'(rsp_illegal), 64'(q[0].ill));
      end
    end
    if (srst) begin
      q.delete();
      rr = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (g >= 0) begin
        e.id = g;
        e.ill = illeg(so[4*g +: 4]);
        e.res = alu_ref(so[4*g +: 4], sa[32*g +: 32], sb[32*g +: 32]);
        e.avail = cyc + 2;
        q.push_back(e);
        rr = (g + 1) % N;
      end
    end
  endtask

  task automatic clr();
    srst = 1'b0; srdy = 1'b1; sv = '0; so = '0; sa = '0; sb = '0;
  endtask

  task automatic idle(input int n);
    clr();
    repeat (n) step();
  endtask

  initial begin
    clr();
    srst = 1'b1;
    rst = 1'b1; req_valid = '0; req_opcode = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    step();
    step();
    check("reset_req_ready", 64'(req_ready), 64'(0));
    check("reset_alu_opcode", 64'(alu_opcode), 64'hf);
    idle(1);
    check("post_reset_rsp_valid", 64'(rsp_valid), 64'(0));
    // single op on requester 2
    clr(); sv = 4'b0100; sa[64 +: 32] = 32'd5; sb[64 +: 32] = 32'd7;
    step();
    check("single_grant", 64'(req_ready), 64'b0100);
    idle(1);
    check("single_not_yet", 64'(rsp_valid), 64'(0));
    idle(1);
    check("single_valid", 64'(rsp_valid), 64'(1));
    check("single_id", 64'(rsp_id), 64'(2));
    check("single_result", 64'(rsp_result), 64'(12));
    check("single_illegal", 64'(rsp_illegal), 64'(0));
    // round robin from a fresh pointer
    clr(); srst = 1'b1; step();
    clr(); sv = '1;
    for (int i = 0; i < N; i++) begin
      sa[32*i +: 32] = 32'(i);
      sb[32*i +: 32] = 32'd1;
    end
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_grant", 64'(req_ready), 64'(1) << (k % N));
      if (k >= 2) check("rr_result", 64'(rsp_result), 64'((k - 2) % N + 1));
    end
    idle(4);
    // backpressure with a full FIFO
    clr(); srdy = 1'b0; sv = 4'b0001; so[3:0] = 4'b0010; sa[31:0] = 32'd3; sb[31:0] = 32'd4;
    grants = 0;
    repeat (5) begin
      step();
      grants += int'(req_ready[0]);
    end
    check("bp_grants", 64'(grants), 64'(2));
    check("bp_stalled", 64'(req_ready), 64'(0));
    srdy = 1'b1;
    step();
    check("bp_resume", 64'(req_ready), 64'b0001);
    check("bp_result", 64'(rsp_result), 64'(12));
    step();
    check("bp_result2", 64'(rsp_result), 64'(12));
    idle(4);
    // illegal opcode
    clr(); sv = 4'b0010; so[7:4] = 4'b0011; sa[63:32] = 32'd9; sb[63:32] = 32'd3;
    step();
    idle(2);
    check("ill_id", 64'(rsp_id), 64'(1));
    check("ill_flag", 64'(rsp_illegal), 64'(1));
    check("ill_result", 64'(rsp_result), 64'(0));
    idle(3);
    // reset while an op is in flight
    clr(); sv = 4'b0100; step();
    clr(); srst = 1'b1; step();
    clr(); sv = '1; step();
    check("rst_flight_valid", 64'(rsp_valid), 64'(0));
    check("rst_flight_grant", 64'(req_ready), 64'b0001);
    idle(4);
    // arithmetic shift routing on requester 3
    clr(); sv = 4'b1000; so[15:12] = 4'b1010; sa[127:96] = 32'h8000_0000; sb[127:96] = 32'd4;
    step();
    idle(2);
    check("sra_id", 64'(rsp_id), 64'(3));
    check("sra_result", 64'(rsp_result), 64'hf800_0000);
    idle(3);
    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      srst = ($urandom % 128) == 0;
      srdy = ($urandom % 4) != 0;
      sv = N'($urandom);
      so = 16'($urandom);
      sa = {$urandom, $urandom, $urandom, $urandom};
      sb = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
